// File: rtl/ps2_host_tx_pkg.sv
// PS/2 host transmit definitions shared with the keyboard side:
// FSM state encodings, command bytes and a sizing helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    STOP,
    ACK,
    RELEASE,
    ERROR
  } tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus deglitch filter for one PS/2 line.
// Ports: i_line raw pin, o_level filtered level, o_fall 1->0 pulse.
module ps2_line_filter #(
  parameter int DEGLITCH = 4
) (
  input  logic clk_crystal,
  input  logic rst_global_n,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = $clog2(DEGLITCH + 1);
  localparam logic [CW-1:0] LAST = CW'(DEGLITCH - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Level flips after DEGLITCH consecutive differing samples.
  always_ff @(posedge clk_crystal or negedge rst_global_n) begin
    if (!rst_global_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_lvl  <= 1'b1;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_line;
      r_s2   <= r_s1;
      r_fall <= 1'b0;
      if (r_s2 == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_lvl  <= r_s2;
        r_cnt  <= '0;
        r_fall <= r_lvl;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_lvl;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain pull-low enables).
// Ports: tx_data/tx_start request; ps2_*_i pins; ps2_*_oe pull-lows;
// tx_busy gates the receiver; tx_done/tx_ack_ok/tx_error report status.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000,
  parameter int DEGLITCH       = 4
) (
  input  logic       clk_crystal,
  input  logic       rst_global_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);

  localparam int TMAX =
    max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  // ERROR occupies the final cycle of each timeout budget.
  localparam logic [TW-1:0] REQ_LAST = TW'(START_TIMEOUT - 2);
  localparam logic [TW-1:0] XFR_LAST = TW'(XFER_TIMEOUT - 2);

  tx_state_e     r_state;
  tx_state_e     w_next;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [3:0]    r_bit_cnt;
  logic          r_data_oe;
  logic          r_ack;
  logic          r_done;
  logic          r_err;

  logic w_clk_lvl;
  logic w_clk_fall;
  logic w_dat_lvl;
  logic w_dat_fall_unused;
  logic w_xfr_exp;
  logic w_tmr_clr;

  ps2_line_filter #(.DEGLITCH(DEGLITCH)) u_clk_filt (
    .clk_crystal  (clk_crystal),
    .rst_global_n (rst_global_n),
    .i_line       (ps2_clk_i),
    .o_level      (w_clk_lvl),
    .o_fall       (w_clk_fall)
  );

  ps2_line_filter #(.DEGLITCH(DEGLITCH)) u_dat_filt (
    .clk_crystal  (clk_crystal),
    .rst_global_n (rst_global_n),
    .i_line       (ps2_data_i),
    .o_level      (w_dat_lvl),
    .o_fall       (w_dat_fall_unused)
  );

  assign w_xfr_exp = (r_timer >= XFR_LAST);
  // One timer, restarted on entry to each timed phase; the
  // transfer budget spans DATA through RELEASE.
  assign w_tmr_clr = (w_next != r_state) &&
                     (w_next inside {INHIBIT, REQ, DATA});

  always_ff @(posedge clk_crystal or negedge rst_global_n) begin
    if (!rst_global_n) r_state <= IDLE;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (tx_start) w_next = INHIBIT;
      INHIBIT: if (r_timer == INH_LAST) w_next = REQ;
      REQ: begin
        if (w_clk_fall)               w_next = DATA;
        else if (r_timer >= REQ_LAST) w_next = ERROR;
      end
      DATA: begin
        if (w_xfr_exp) w_next = ERROR;
        else if (w_clk_fall && r_bit_cnt == 4'd8)
          w_next = STOP;
      end
      STOP: begin
        if (w_xfr_exp)       w_next = ERROR;
        else if (w_clk_fall) w_next = ACK;
      end
      ACK: begin
        if (w_xfr_exp)       w_next = ERROR;
        else if (w_clk_fall) w_next = RELEASE;
      end
      RELEASE: begin
        if (w_xfr_exp)                   w_next = ERROR;
        else if (w_clk_lvl && w_dat_lvl) w_next = IDLE;
      end
      ERROR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_crystal or negedge rst_global_n) begin
    if (!rst_global_n) begin
      r_timer   <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
      r_data_oe <= 1'b0;
      r_ack     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_tmr_clr)         r_timer <= '0;
      else if (r_timer != '1) r_timer <= r_timer + 1'b1;
      case (r_state)
        IDLE: begin
          if (tx_start) begin
            r_shift   <= tx_data;
            r_par     <= ~^tx_data;
            r_ack     <= 1'b0;
            r_bit_cnt <= '0;
          end
        end
        INHIBIT: begin
          if (w_next == REQ) r_data_oe <= 1'b1;
        end
        REQ: begin
          if (w_next == DATA) begin
            r_data_oe <= ~r_shift[0];
            r_bit_cnt <= 4'd1;
          end
        end
        DATA: begin
          if (w_next == STOP) begin
            r_data_oe <= ~r_par;
          end else if (w_next == DATA && w_clk_fall) begin
            r_data_oe <= ~r_shift[r_bit_cnt[2:0]];
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_next == ACK) r_data_oe <= 1'b0;
        end
        ACK: begin
          if (w_next == RELEASE) r_ack <= ~w_dat_lvl;
        end
        RELEASE: begin
          if (w_next == IDLE) r_done <= 1'b1;
        end
        ERROR: begin
          r_err <= 1'b1;
          r_ack <= 1'b0;
        end
        default: ;
      endcase
      if (w_next == ERROR) r_data_oe <= 1'b0;
    end
  end

  always_comb begin
    ps2_clk_oe  = (r_state == INHIBIT);
    ps2_data_oe = r_data_oe;
    tx_busy     = (r_state != IDLE);
    tx_done     = r_done;
    tx_ack_ok   = r_ack;
    tx_error    = r_err;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model.
// Device clock half-period is 20 system cycles.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_ack_ok;
  logic       tx_error;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (50),
    .START_TIMEOUT  (400),
    .XFER_TIMEOUT   (4000),
    .DEGLITCH       (4)
  ) dut (
    .clk_crystal  (clk),
    .rst_global_n (rst_n),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .ps2_clk_oe   (ps2_clk_oe),
    .ps2_data_oe  (ps2_data_oe),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_ack_ok    (tx_ack_ok),
    .tx_error     (tx_error)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_req(output int n, output logic d);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    d = ps2_data_oe;
  endtask

  task automatic dev_pulse(output logic s);
    dev_clk_low = 1'b1;
    repeat (19) @(negedge clk);
    s = ps2_data_i;
    @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic dev_frame(input bit ack, input bit poke,
                           output logic [9:0] smp);
    logic s;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_pulse(s);
      smp[k] = s;
      if (poke && k == 3) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
      end
    end
    dev_dat_low = ack;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_end(output int nd, output int ne,
                          output logic ack_at,
                          output logic busy_at);
    nd = 0;
    ne = 0;
    ack_at  = 1'bx;
    busy_at = 1'bx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done) begin
        nd++;
        ack_at  = tx_ack_ok;
        busy_at = tx_busy;
      end
      if (tx_error) ne++;
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] b,
                       input logic par, input bit ack,
                       input bit poke);
    int         inh;
    logic       dreq;
    logic [9:0] smp;
    int         nd;
    int         ne;
    logic       ack_at;
    logic       busy_at;
    send(b);
    wait_req(inh, dreq);
    chk({tag, "_inhibit_len"}, inh, 50);
    chk({tag, "_start_bit"}, dreq, 1'b1);
    dev_frame(ack, poke, smp);
    chk({tag, "_data"}, smp[7:0], b);
    chk({tag, "_parity"}, smp[8], par);
    chk({tag, "_stop"}, smp[9], 1'b1);
    wait_end(nd, ne, ack_at, busy_at);
    chk({tag, "_done_cnt"}, nd, 1);
    chk({tag, "_err_cnt"}, ne, 0);
    chk({tag, "_ack_at_done"}, ack_at, ack);
    chk({tag, "_busy_at_done"}, busy_at, 1'b0);
    chk({tag, "_ack_held"}, tx_ack_ok, ack);
    chk({tag, "_busy_after"}, tx_busy, 1'b0);
  endtask

  initial begin
    int   inh;
    int   c;
    int   nd;
    int   ne;
    logic d;
    logic s;

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {ps2_clk_oe, ps2_data_oe, tx_busy,
         tx_done, tx_ack_ok, tx_error}, 6'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    frame("ed", PS2_CMD_SET_LEDS, 1'b1, 1'b1, 1'b0);
    frame("x01", 8'h01, 1'b0, 1'b1, 1'b0);
    frame("x00", 8'h00, 1'b1, 1'b1, 1'b0);
    frame("noack", PS2_CMD_ENABLE, 1'b0, 1'b0, 1'b0);

    send(PS2_CMD_ENABLE);
    wait_req(inh, d);
    chk("to_inhibit_len", inh, 50);
    chk("to_start_bit", d, 1'b1);
    c = 0;
    while (!tx_error && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("to_latency", c, 400);
    chk("to_lines_busy", {ps2_clk_oe, ps2_data_oe, tx_busy}, 3'b0);
    chk("to_ack_ok", tx_ack_ok, 1'b0);
    @(negedge clk);
    chk("to_err_pulse_len", tx_error, 1'b0);
    repeat (20) @(negedge clk);

    send(8'hA5);
    wait_req(inh, d);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 4; k++) dev_pulse(s);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_bit4_driven", ps2_data_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_immediate",
        {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error},
        5'b0);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    ne = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_done) nd++;
      if (tx_error) ne++;
    end
    chk("rst_no_pulses", nd + ne, 0);
    chk("rst_idle", tx_busy, 1'b0);

    frame("ff", PS2_CMD_RESET, 1'b1, 1'b1, 1'b0);
    frame("poke", 8'h3C, 1'b1, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
